// File: rtl/palt_nios_gpio_pulse_drv_if.sv
// Level/pulse bundle between the Nios PIO port and the pulse driver.
// Master drives the PIO level bus; slave publishes conditioned outputs.
interface palt_nios_gpio_pulse_drv_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] gpio_in;
    logic [WIDTH-1:0] level_out;
    logic [WIDTH-1:0] pulse_out;
    logic [WIDTH-1:0] busy;
    logic [WIDTH-1:0] edge_drop;
    logic             tick;

    modport master (
        output gpio_in,
        input  level_out,
        input  pulse_out,
        input  busy,
        input  edge_drop,
        input  tick
    );

    modport slave (
        input  gpio_in,
        output level_out,
        output pulse_out,
        output busy,
        output edge_drop,
        output tick
    );
endinterface

// File: rtl/palt_nios_gpio_pulse_drv.sv
// Nios PIO output conditioner: synchronise, re-publish level, and fire
// fixed-width rate-limited pulses on rising edges, timed by a shared tick.
module palt_nios_gpio_pulse_drv #(
    parameter int               WIDTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VAL   = WIDTH'(2'b10),
    parameter int               SYNC_STAGES = 2,
    parameter int               PRESCALE    = 50000,
    parameter int               PULSE_TICKS = 100,
    parameter int               HOLD_TICKS  = 50
) (
    input  logic                         clk,
    input  logic                         reset_n,
    palt_nios_gpio_pulse_drv_if.slave    bus
);

    localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int CMAX = (PULSE_TICKS > HOLD_TICKS) ? PULSE_TICKS : HOLD_TICKS;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [PW-1:0] P_LAST  = PW'(PRESCALE - 1);
    localparam logic [CW-1:0] PT_LAST = CW'(PULSE_TICKS - 1);
    localparam logic [CW-1:0] HT_LAST = CW'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_HOLD
    } state_t;

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_hist;
    logic [PW-1:0]    r_pcnt;
    logic             r_tick;
    state_t           r_state [WIDTH];
    logic [CW-1:0]    r_cnt   [WIDTH];
    logic [WIDTH-1:0] r_drop;

    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_pulse;
    logic [WIDTH-1:0] w_busy;

    assign w_level = r_sync[SYNC_STAGES-1];
    assign w_rise  = w_level & ~r_hist;

    // Synchroniser chain and one-cycle edge history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= RESET_VAL;
            end
            r_hist <= RESET_VAL;
        end else begin
            r_sync[0] <= bus.gpio_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_hist <= w_level;
        end
    end

    // Free-running prescaler; tick is a registered strobe on the terminal count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pcnt <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_pcnt == P_LAST);
            if (r_pcnt == P_LAST) begin
                r_pcnt <= '0;
            end else begin
                r_pcnt <= r_pcnt + 1'b1;
            end
        end
    end

    // Per-channel pulse/hold sequencer; rises outside IDLE are dropped and flagged
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_state[i] <= S_IDLE;
                r_cnt[i]   <= '0;
            end
            r_drop <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                r_drop[i] <= 1'b0;
                unique case (r_state[i])
                    S_IDLE: begin
                        if (w_rise[i]) begin
                            r_state[i] <= S_PULSE;
                            r_cnt[i]   <= '0;
                        end
                    end
                    S_PULSE: begin
                        r_drop[i] <= w_rise[i];
                        if (r_tick) begin
                            if (r_cnt[i] == PT_LAST) begin
                                r_cnt[i]   <= '0;
                                r_state[i] <= (HOLD_TICKS == 0) ? S_IDLE : S_HOLD;
                            end else begin
                                r_cnt[i] <= r_cnt[i] + 1'b1;
                            end
                        end
                    end
                    S_HOLD: begin
                        r_drop[i] <= w_rise[i];
                        if (r_tick) begin
                            if (r_cnt[i] == HT_LAST) begin
                                r_cnt[i]   <= '0;
                                r_state[i] <= S_IDLE;
                            end else begin
                                r_cnt[i] <= r_cnt[i] + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state[i] <= S_IDLE;
                        r_cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    // Decode channel outputs from registered state
    always_comb begin
        w_pulse = '0;
        w_busy  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pulse[i] = (r_state[i] == S_PULSE);
            w_busy[i]  = (r_state[i] != S_IDLE);
        end
    end

    assign bus.level_out = w_level;
    assign bus.pulse_out = w_pulse;
    assign bus.busy      = w_busy;
    assign bus.edge_drop = r_drop;
    assign bus.tick      = r_tick;

endmodule

// File: tb/tb_palt_nios_gpio_pulse_drv.sv
// Self-checking bench for palt_nios_gpio_pulse_drv against a tick-schedule
// reference model (pulse/hold end edges computed from tick arithmetic).
module tb_palt_nios_gpio_pulse_drv;

    localparam int         W   = 2;
    localparam logic [1:0] RV  = 2'b10;
    localparam int         PS  = 4;
    localparam int         PT  = 3;
    localparam int         HT  = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    palt_nios_gpio_pulse_drv_if #(.WIDTH(W)) bus ();

    palt_nios_gpio_pulse_drv #(
        .WIDTH       (W),
        .RESET_VAL   (RV),
        .SYNC_STAGES (2),
        .PRESCALE    (PS),
        .PULSE_TICKS (PT),
        .HOLD_TICKS  (HT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: n = clock edges since reset release.
    // Level after edge n is gpio sampled at edge n-1 (RV for n<2).
    // Each accepted pulse is a window of edges [s_e, p_e) / [s_e, h_e).
    int         n;
    logic [1:0] g_last;
    logic [1:0] m_lvl, m_lvl_prev;
    logic [1:0] m_pulse, m_busy, m_drop;
    logic       m_tick;
    int         s_e [2];
    int         p_e [2];
    int         h_e [2];
    int         d_e [2];

    // Edge k samples a tick iff tick was high after edge k-1, i.e. (k-1)%PS==0, k>1
    function automatic int next_ts(input int k);
        int r;
        r = k;
        while (r < 2 || ((r - 1) % PS) != 0) r++;
        return r;
    endfunction

    task automatic model_reset();
        n          = 0;
        m_lvl      = RV;
        m_lvl_prev = RV;
        g_last     = RV;
        m_pulse    = '0;
        m_busy     = '0;
        m_drop     = '0;
        m_tick     = 1'b0;
        for (int c = 0; c < 2; c++) begin
            s_e[c] = 0;
            p_e[c] = 0;
            h_e[c] = 0;
            d_e[c] = -1;
        end
    endtask

    task automatic step();
        int k;
        @(posedge clk);
        n++;
        m_lvl_prev = m_lvl;
        m_lvl      = (n >= 2) ? g_last : RV;
        g_last     = bus.gpio_in;
        for (int c = 0; c < 2; c++) begin
            if (m_lvl[c] && !m_lvl_prev[c]) begin
                if (n >= h_e[c]) begin
                    s_e[c] = n + 1;
                    k = n + 1;
                    for (int t = 0; t < PT; t++) k = next_ts(k + 1);
                    p_e[c] = k;
                    for (int t = 0; t < HT; t++) k = next_ts(k + 1);
                    h_e[c] = k;
                end else begin
                    d_e[c] = n + 1;
                end
            end
            m_pulse[c] = (n >= s_e[c]) && (n < p_e[c]);
            m_busy[c]  = (n >= s_e[c]) && (n < h_e[c]);
            m_drop[c]  = (n == d_e[c]);
        end
        m_tick = (n > 0) && ((n % PS) == 0);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int ticks;
        reset_n     = 1'b0;
        bus.gpio_in = RV;
        model_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({bus.level_out, bus.pulse_out, bus.busy, bus.edge_drop, bus.tick} !== {RV, 7'b0}) begin
            fails++;
            $display("FAIL reset_hold got %b exp %b",
                     {bus.level_out, bus.pulse_out, bus.busy, bus.edge_drop, bus.tick}, {RV, 7'b0});
        end
        reset_n = 1'b1;
        ticks   = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (bus.tick === 1'b1) ticks++;
            tests++;
            if ({bus.level_out, bus.pulse_out, bus.busy, bus.edge_drop} !== {RV, 6'b0}) begin
                fails++;
                $display("FAIL reset_quiet n=%0d got %b", n,
                         {bus.level_out, bus.pulse_out, bus.busy, bus.edge_drop});
            end
            tests++;
            if (bus.tick !== m_tick) begin
                fails++;
                $display("FAIL reset_tick n=%0d got %b exp %b", n, bus.tick, m_tick);
            end
        end
        tests++;
        if (ticks != 12) begin
            fails++;
            $display("FAIL reset_tick_count got %0d exp 12", ticks);
        end
    endtask

    task automatic test_single_pulse();
        int plen, blen;
        plen = 0;
        blen = 0;
        bus.gpio_in = 2'b11;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus.pulse_out[0] === 1'b1) plen++;
            if (bus.busy[0] === 1'b1 && bus.pulse_out[0] === 1'b0) blen++;
            tests++;
            if ({bus.level_out, bus.pulse_out, bus.busy, bus.edge_drop, bus.tick} !==
                {m_lvl, m_pulse, m_busy, m_drop, m_tick}) begin
                fails++;
                $display("FAIL single n=%0d got %b exp %b", n,
                         {bus.level_out, bus.pulse_out, bus.busy, bus.edge_drop, bus.tick},
                         {m_lvl, m_pulse, m_busy, m_drop, m_tick});
            end
        end
        tests++;
        if (plen < 9 || plen > 12) begin
            fails++;
            $display("FAIL single_width got %0d exp 9..12", plen);
        end
        tests++;
        if (blen != 8) begin
            fails++;
            $display("FAIL single_hold got %0d exp 8", blen);
        end
    endtask

    task automatic test_drop_in_pulse();
        int plen, drops;
        plen  = 0;
        drops = 0;
        for (int c = 0; c < 40; c++) begin
            bus.gpio_in[0] = (c < 3) ? 1'b0 : (c < 8) ? 1'b1 : (c < 10) ? 1'b0 : 1'b1;
            step();
            if (bus.pulse_out[0] === 1'b1) plen++;
            if (bus.edge_drop[0] === 1'b1) drops++;
            tests++;
            if ({bus.level_out, bus.pulse_out, bus.busy, bus.edge_drop, bus.tick} !==
                {m_lvl, m_pulse, m_busy, m_drop, m_tick}) begin
                fails++;
                $display("FAIL drop n=%0d got %b exp %b", n,
                         {bus.level_out, bus.pulse_out, bus.busy, bus.edge_drop, bus.tick},
                         {m_lvl, m_pulse, m_busy, m_drop, m_tick});
            end
        end
        tests++;
        if (drops != 1) begin
            fails++;
            $display("FAIL drop_count got %0d exp 1", drops);
        end
        tests++;
        if (plen < 9 || plen > 12) begin
            fails++;
            $display("FAIL drop_width got %0d exp 9..12", plen);
        end
    endtask

    // Re-rise timed so the level rise is seen in the cycle HOLD ends (offset 2)
    // or the first IDLE cycle (offset 1).
    task automatic test_rerise(input int offset, input int cycles,
                               input int exp_pulses, input int exp_drops);
        int   tgt, pulses, drops;
        logic prev;
        tgt    = 0;
        pulses = 0;
        drops  = 0;
        prev   = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            if (c == 5) tgt = h_e[0];
            if (c < 2)      bus.gpio_in[0] = 1'b0;
            else if (c < 5) bus.gpio_in[0] = 1'b1;
            else            bus.gpio_in[0] = (n + 1 >= tgt - offset);
            step();
            if (bus.pulse_out[0] === 1'b1 && !prev) pulses++;
            prev = bus.pulse_out[0];
            if (bus.edge_drop[0] === 1'b1) drops++;
            tests++;
            if ({bus.level_out, bus.pulse_out, bus.busy, bus.edge_drop, bus.tick} !==
                {m_lvl, m_pulse, m_busy, m_drop, m_tick}) begin
                fails++;
                $display("FAIL rerise%0d n=%0d got %b exp %b", offset, n,
                         {bus.level_out, bus.pulse_out, bus.busy, bus.edge_drop, bus.tick},
                         {m_lvl, m_pulse, m_busy, m_drop, m_tick});
            end
        end
        tests++;
        if (pulses != exp_pulses || drops != exp_drops) begin
            fails++;
            $display("FAIL rerise%0d_counts got pulses=%0d drops=%0d exp %0d/%0d",
                     offset, pulses, drops, exp_pulses, exp_drops);
        end
    endtask

    task automatic test_hold_exit_drop();
        test_rerise(2, 40, 1, 1);
    endtask

    task automatic test_back_to_back();
        test_rerise(1, 60, 2, 0);
    endtask

    task automatic test_two_channels();
        int   r0, r1;
        logic [1:0] prev;
        r0   = -1;
        r1   = -1;
        prev = 2'b00;
        for (int c = 0; c < 46; c++) begin
            bus.gpio_in = (c < 3) ? 2'b10 : (c < 6) ? 2'b01 : 2'b11;
            step();
            if (bus.pulse_out[0] === 1'b1 && !prev[0] && r0 < 0) r0 = c;
            if (bus.pulse_out[1] === 1'b1 && !prev[1] && r1 < 0) r1 = c;
            prev = bus.pulse_out;
            tests++;
            if ({bus.level_out, bus.pulse_out, bus.busy, bus.edge_drop, bus.tick} !==
                {m_lvl, m_pulse, m_busy, m_drop, m_tick}) begin
                fails++;
                $display("FAIL two_ch n=%0d got %b exp %b", n,
                         {bus.level_out, bus.pulse_out, bus.busy, bus.edge_drop, bus.tick},
                         {m_lvl, m_pulse, m_busy, m_drop, m_tick});
            end
        end
        tests++;
        if (r0 < 0 || r1 < 0 || r0 >= r1) begin
            fails++;
            $display("FAIL two_ch_order got r0=%0d r1=%0d exp 0<=r0<r1", r0, r1);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.gpio_in[$urandom_range(0, 1)] = ~bus.gpio_in[$urandom_range(0, 1)];
            end
            if ($urandom_range(0, 15) == 0) bus.gpio_in = 2'($urandom);
            step();
            tests++;
            if ({bus.level_out, bus.pulse_out, bus.busy, bus.edge_drop, bus.tick} !==
                {m_lvl, m_pulse, m_busy, m_drop, m_tick}) begin
                fails++;
                $display("FAIL random n=%0d got %b exp %b", n,
                         {bus.level_out, bus.pulse_out, bus.busy, bus.edge_drop, bus.tick},
                         {m_lvl, m_pulse, m_busy, m_drop, m_tick});
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        int highs;
        highs = 0;
        bus.gpio_in = 2'b10;
        repeat (25) step();
        bus.gpio_in = 2'b11;
        repeat (6) step();
        tests++;
        if (bus.pulse_out !== m_pulse || m_pulse[0] !== 1'b1) begin
            fails++;
            $display("FAIL midrst_pre got %b exp %b", bus.pulse_out, m_pulse);
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if ({bus.level_out, bus.pulse_out, bus.busy, bus.edge_drop, bus.tick} !== {RV, 7'b0}) begin
            fails++;
            $display("FAIL midrst_async got %b exp %b",
                     {bus.level_out, bus.pulse_out, bus.busy, bus.edge_drop, bus.tick}, {RV, 7'b0});
        end
        bus.gpio_in = RV;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus.pulse_out !== 2'b00) highs++;
            tests++;
            if ({bus.level_out, bus.pulse_out, bus.busy, bus.edge_drop, bus.tick} !==
                {m_lvl, m_pulse, m_busy, m_drop, m_tick}) begin
                fails++;
                $display("FAIL midrst_after n=%0d got %b exp %b", n,
                         {bus.level_out, bus.pulse_out, bus.busy, bus.edge_drop, bus.tick},
                         {m_lvl, m_pulse, m_busy, m_drop, m_tick});
            end
        end
        tests++;
        if (highs != 0) begin
            fails++;
            $display("FAIL midrst_nopulse got %0d pulse cycles exp 0", highs);
        end
    endtask

    initial begin
        bus.gpio_in = RV;
        test_reset();
        test_single_pulse();
        test_drop_in_pulse();
        test_hold_exit_drop();
        test_back_to_back();
        test_two_channels();
        test_random();
        test_reset_mid_pulse();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
